// File: rtl/lc3b_pkg.sv
// Shared decode constants for the LC-3b control-store sequencer: opcode field
// positions, control-store geometry, illegal-opcode mask and slot state encoding.
package lc3b_pkg;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int IR_STEER_A = 11;
   localparam int IR_STEER_B = 5;

   localparam int CS_ADDR_WIDTH = 6;
   localparam int CS_WORD_WIDTH = 23;
   localparam logic [15:0] ILLEGAL_OPS_DEFAULT = 16'h0D00;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } slot_state_t;

   // Microcode entry: opcode plus two steering bits picking the variant.
   function automatic logic [CS_ADDR_WIDTH-1:0] cs_addr_of(input logic [15:0] ir);
      return {ir[OPC_HI:OPC_LO], ir[IR_STEER_A], ir[IR_STEER_B]};
   endfunction

endpackage

// File: rtl/cs_addr_gen.sv
// Combinational IR-to-control-store-address mapping with illegal-opcode lookup;
// kept separate so later decode logic can reuse it.
module cs_addr_gen
   import lc3b_pkg::*;
#(
   parameter int          ADDR_WIDTH  = CS_ADDR_WIDTH,
   parameter logic [15:0] ILLEGAL_OPS = ILLEGAL_OPS_DEFAULT
) (
   input  logic [15:0]           ir,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  illegal
);

   assign addr    = cs_addr_of(ir);
   assign illegal = ILLEGAL_OPS[ir[OPC_HI:OPC_LO]];

endmodule

// File: rtl/cs_sequencer.sv
// Decode-stage sequencer: one-slot skid between fetch and execute that aligns IR/PC
// with the synchronous control-store read. Optional counters under CS_SEQ_PERF_EN.
module cs_sequencer
   import lc3b_pkg::*;
#(
   parameter int          CS_WIDTH    = CS_WORD_WIDTH,
   parameter int          ADDR_WIDTH  = CS_ADDR_WIDTH,
   parameter logic [15:0] ILLEGAL_OPS = ILLEGAL_OPS_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [15:0]           in_ir,
   input  logic [15:0]           in_pc,
   input  logic                  flush,
   output logic [ADDR_WIDTH-1:0] cs_addr,
   input  logic [CS_WIDTH-1:0]   cs_bits,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [15:0]           out_ir,
   output logic [15:0]           out_pc,
   output logic [CS_WIDTH-1:0]   out_cs,
   output logic                  out_illegal
`ifdef CS_SEQ_PERF_EN
   ,
   output logic [15:0]           stall_cnt,
   output logic [15:0]           illegal_cnt
`endif
);

   slot_state_t           state, state_nxt;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic                  in_illegal;

   cs_addr_gen #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .ILLEGAL_OPS (ILLEGAL_OPS)
   ) u_in_gen (
      .ir      (in_ir),
      .addr    (in_addr),
      .illegal (in_illegal)
   );

   assign in_ready  = !flush && (state == S_EMPTY || out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == S_FULL);

   // While holding, re-address the held IR so the ROM keeps returning its word.
   assign cs_addr = accept ? in_addr : cs_addr_of(out_ir);
   assign out_cs  = (out_valid && !out_illegal) ? cs_bits : '0;

   // NOTE: default assigned first so every path drives state_nxt; no latch.
   always_comb begin
      state_nxt = state;
      if (flush)
         state_nxt = S_EMPTY;
      else if (accept)
         state_nxt = S_FULL;
      else if (state == S_FULL && out_ready)
         state_nxt = S_EMPTY;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_EMPTY;
         out_ir      <= '0;
         out_pc      <= '0;
         out_illegal <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            out_ir      <= in_ir;
            out_pc      <= in_pc;
            out_illegal <= in_illegal;
         end
      end
   end

`ifdef CS_SEQ_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt   <= '0;
         illegal_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         if (accept && in_illegal && illegal_cnt != 16'hFFFF)
            illegal_cnt <= illegal_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cs_sequencer.sv
// Scoreboard bench for cs_sequencer with a behavioural control-store ROM;
// also checks the CS_SEQ_PERF_EN counters when that macro is defined.
module tb_cs_sequencer;

   localparam logic [15:0] ILL_MASK = 16'h0D00;

   typedef struct {
      logic [15:0] ir;
      logic [15:0] pc;
      logic        ill;
      logic [22:0] cs;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
   logic [15:0] in_ir, in_pc, out_ir, out_pc;
   logic [5:0]  cs_addr;
   logic [22:0] cs_bits, out_cs;
`ifdef CS_SEQ_PERF_EN
   logic [15:0] stall_cnt, illegal_cnt;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   logic        m_full;
   logic [15:0] m_ir;
   int          m_stall, m_ill;

   cs_sequencer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_ir       (in_ir),
      .in_pc       (in_pc),
      .flush       (flush),
      .cs_addr     (cs_addr),
      .cs_bits     (cs_bits),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ir      (out_ir),
      .out_pc      (out_pc),
      .out_cs      (out_cs),
      .out_illegal (out_illegal)
`ifdef CS_SEQ_PERF_EN
      ,
      .stall_cnt   (stall_cnt),
      .illegal_cnt (illegal_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] addr_f(input logic [15:0] ir);
      return {ir[15:12], ir[11], ir[5]};
   endfunction

   function automatic logic [22:0] rom_f(input logic [5:0] a);
      return {a, ~a, a ^ 6'h2A, a[4:0] + 5'd3};
   endfunction

   // Synchronous-read control store model.
   always @(posedge clk) cs_bits <= rom_f(cs_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      sb_q.delete();
      m_full  = 1'b0;
      m_ir    = '0;
      m_stall = 0;
      m_ill   = 0;
   endtask

   // Checks the current cycle against the model, then advances the model past the edge.
   task automatic observe();
      logic exp_ready, acc;
      exp_t e;
      exp_ready = !flush && (!m_full || out_ready);
      acc       = in_valid && exp_ready;
      check("in_ready", in_ready, exp_ready);
      check("out_valid", out_valid, m_full);
      check("cs_addr", cs_addr, acc ? addr_f(in_ir) : addr_f(m_ir));
      if (m_full) begin
         if (sb_q.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            check("out_ir", out_ir, sb_q[0].ir);
            check("out_pc", out_pc, sb_q[0].pc);
            check("out_illegal", out_illegal, sb_q[0].ill);
            check("out_cs", out_cs, sb_q[0].cs);
         end
      end else begin
         check("out_cs_idle", out_cs, 0);
      end
      if (m_full && !out_ready && m_stall < 16'hFFFF) m_stall++;
      if (flush) begin
         if (m_full && sb_q.size() > 0) void'(sb_q.pop_front());
         m_full = 1'b0;
      end else begin
         if (m_full && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
         if (acc) begin
            e.ir  = in_ir;
            e.pc  = in_pc;
            e.ill = ILL_MASK[in_ir[15:12]];
            e.cs  = e.ill ? 23'd0 : rom_f(addr_f(in_ir));
            sb_q.push_back(e);
            if (e.ill && m_ill < 16'hFFFF) m_ill++;
            m_ir   = in_ir;
            m_full = 1'b1;
         end else if (out_ready) begin
            m_full = 1'b0;
         end
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] ir, input logic [15:0] pc,
                        input logic ordy, input logic fl);
      @(negedge clk);
      in_valid  = v;
      in_ir     = ir;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      #2;
      observe();
   endtask

   initial begin
      reset_n = 1'b0;
      in_valid = 1'b0; in_ir = '0; in_pc = '0; out_ready = 1'b1; flush = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Reset state, then ADD immediate.
      drive(0, 16'h0000, 16'h0000, 1, 0);
      check("rst_out_ir", out_ir, 0);
      drive(1, 16'h12A3, 16'h3000, 1, 0);
      check("add_addr", cs_addr, 6'd5);
      drive(0, 16'h0000, 16'h0000, 1, 0);
      check("add_cs", out_cs, rom_f(6'd5));

      // JSR / JSRR back to back.
      drive(1, 16'h4800, 16'h3002, 1, 0);
      check("jsr_addr", cs_addr, 6'd18);
      drive(1, 16'h4000, 16'h3004, 1, 0);
      check("jsrr_addr", cs_addr, 6'd16);
      drive(0, 16'h0000, 16'h0000, 1, 0);

      // Illegal opcode forces NOP.
      drive(1, 16'hA000, 16'h3006, 1, 0);
      check("ill_addr", cs_addr, 6'd40);
      drive(0, 16'h0000, 16'h0000, 1, 0);
      check("ill_flag", out_illegal, 1);

      // Stall while FULL with a pending input, then release.
      drive(1, 16'h1234, 16'h3008, 0, 0);
      for (int i = 0; i < 3; i++) drive(1, 16'h5678, 16'h300A, 0, 0);
      drive(1, 16'h5678, 16'h300A, 1, 0);
      check("stall_release_ready", in_ready, 1);
      drive(0, 16'h0000, 16'h0000, 1, 0);

      // Flush while FULL drops both held and incoming instructions.
      drive(1, 16'h3000, 16'h300C, 0, 0);
      drive(1, 16'h7777, 16'h300E, 0, 1);
      drive(0, 16'h0000, 16'h0000, 1, 0);
      check("flush_empty", out_valid, 0);

      // Asynchronous reset mid-stall.
      drive(1, 16'h2222, 16'h3010, 0, 0);
      drive(0, 16'h0000, 16'h0000, 0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_ir", out_ir, 0);
      check("arst_pc", out_pc, 0);
      check("arst_ill", out_illegal, 0);
      check("arst_cs", out_cs, 0);
      check("arst_addr", cs_addr, 0);
`ifdef CS_SEQ_PERF_EN
      check("arst_stall_cnt", stall_cnt, 0);
      check("arst_illegal_cnt", illegal_cnt, 0);
`endif
      @(negedge clk);
      reset_n = 1'b1;
      model_clear();
      drive(1, 16'h6040, 16'h4000, 1, 0);
      drive(0, 16'h0000, 16'h0000, 1, 0);
      check("post_rst_ir", out_ir, 16'h6040);

      // Random traffic.
      for (int i = 0; i < 300; i++)
         drive($urandom_range(3, 0) != 0, 16'($urandom), 16'($urandom),
               $urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0);

      for (int i = 0; i < 3; i++) drive(0, 16'h0000, 16'h0000, 1, 0);
      check("sb_empty", sb_q.size(), 0);
`ifdef CS_SEQ_PERF_EN
      check("stall_cnt", stall_cnt, m_stall);
      check("illegal_cnt", illegal_cnt, m_ill);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cs_sequencer.md
Name: cs_sequencer

Overview:
Decode-stage sequencer for the 64x23 synchronous-read control store ROM. It accepts fetched instructions over a valid/ready handshake and forms the 6-bit microcode address. It compensates for the ROM's one-cycle read latency and presents aligned {IR, PC, control word} to the execute stage. It handles backpressure, flush and illegal-opcode flagging.

Parameters:
CS_WIDTH, 23, control word width (matches control store)
ADDR_WIDTH, 6, control store address width
ILLEGAL_OPS, 16'h0D00, one bit per opcode; set bit = opcode has no microcode (8, 10, 11)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  sequencer can accept this cycle
in_ir  in  16  instruction word
in_pc  in  16  PC of instruction
flush  in  1  squash held/incoming instruction (branch redirect)
cs_addr  out  ADDR_WIDTH  address to control store ROM (combinational)
cs_bits  in  CS_WIDTH  ROM data, valid one cycle after cs_addr
out_valid  out  1  execute-stage payload valid
out_ready  in  1  execute stage accepts
out_ir  out  16  registered IR
out_pc  out  16  registered PC
out_cs  out  CS_WIDTH  control word for out_ir
out_illegal  out  1  out_ir opcode flagged in ILLEGAL_OPS

Behaviour:
- Address format: cs_addr = {ir[15:12], ir[11], ir[5]}.
- State machine: one output slot, states EMPTY and FULL.
- in_ready = !flush && (state==EMPTY || out_ready).
- accept = in_valid && in_ready.
- cs_addr = accept ? addr(in_ir) : addr(out_ir). While holding, the ROM re-reads the same entry, so cs_bits stays stable without a capture register.
- On accept: out_ir/out_pc/out_illegal register on the same edge; state becomes FULL.
- Latency: instruction accepted in cycle N appears with correct out_cs in cycle N+1.
- FULL and out_ready=1 with no accept: goes to EMPTY.
- FULL and out_ready=1 with accept: stays FULL with the new payload (back-to-back, 1 instr/cycle).
- FULL and out_ready=0: all out_* are held; in_ready=0.
- EMPTY and no accept: stays EMPTY.
- flush: next state EMPTY regardless of out_ready. The incoming instruction is dropped (in_ready=0). The held payload is discarded. Flush overrides everything except reset.
- out_valid = (state==FULL).
- out_cs = out_valid && !out_illegal ? cs_bits : 0. This keeps X off the bus after reset and forces NOP on illegal opcodes.
- out_illegal = ILLEGAL_OPS[out_ir[15:12]], registered with out_ir.
- Reset (async, any time including mid-stall):
  - state=EMPTY; out_valid=0; out_ir=0; out_pc=0; out_illegal=0; out_cs=0.
  - cs_addr=0 (derived from out_ir=0).
  - in_ready goes 1 on the first cycle after release.
- No payload is duplicated or lost except by flush.

Optional Feature:
CS_SEQ_PERF_EN:
- Defined: adds 16-bit outputs stall_cnt and illegal_cnt.
  - stall_cnt increments each cycle out_valid && !out_ready.
  - illegal_cnt increments on each accepted illegal opcode.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters absent; logic otherwise identical.

Decomposition:
- Shared package lc3b_pkg: opcode field bit positions, ADDR_WIDTH/CS_WIDTH constants, ILLEGAL_OPS default, EMPTY/FULL state encoding.
- One natural sub-module, cs_addr_gen: combinational IR-to-address mapping plus illegal lookup, reused by future decode logic. Control store ROM instantiated alongside at top level, not inside.

Test Plan:
- ADD imm, in_ir=16'h12A3, out_ready=1 -> cs_addr=6'd5 in accept cycle; next cycle out_valid=1, out_cs=control store entry 5, out_ir=16'h12A3.
- JSR, in_ir=16'h4800 followed back-to-back by 16'h4000 -> cs_addr 18 then 16; out_cs tracks entries 18, 16 on consecutive cycles; in_ready stays 1.
- Illegal, in_ir=16'hA000 -> cs_addr=6'd40; next cycle out_illegal=1, out_cs=0, out_valid=1.
- Stall, out_ready=0 for 3 cycles while FULL -> out_ir/out_pc/out_cs unchanged, in_ready=0, cs_addr constant; on out_ready=1 the pending input is accepted that same cycle.
- Flush asserted while FULL with in_valid=1 -> next cycle out_valid=0, incoming IR never appears.
- reset_n pulsed low mid-stall -> all outputs 0 immediately; after release, first new instruction emerges with latency 1.
